// File: rtl/duc_pkg.sv
// Shared constants for the multi-channel fs/4 digital up/down converter.
// Holds the mode encoding, the quarter-rate phase table and the term selector.
package duc_pkg;

  localparam int PHASE_W = 2;

  localparam logic [1:0] MODE_BYP  = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_MUTE = 2'b11;

  // (cos, sin) per phase index; every entry has exactly one non-zero term.
  localparam logic signed [1:0] PH_COS [4] = '{2'sd0, -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] PH_SIN [4] = '{2'sd1, 2'sd0, -2'sd1, 2'sd0};

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_POS_I,
    SEL_NEG_I,
    SEL_POS_Q,
    SEL_NEG_Q
  } term_sel_e;

  function automatic term_sel_e term_select(input logic [1:0] mode,
                                            input logic [PHASE_W-1:0] phase);
    term_sel_e sel;
    if (mode == MODE_MUTE)                sel = SEL_ZERO;
    else if (mode == MODE_BYP)            sel = SEL_POS_I;
    else if (PH_COS[phase] == 2'sd1)      sel = SEL_POS_I;
    else if (PH_COS[phase] == -2'sd1)     sel = SEL_NEG_I;
    else if (PH_SIN[phase] == 2'sd1)      sel = SEL_POS_Q;
    else                                  sel = SEL_NEG_Q;
    return sel;
  endfunction

endpackage

// File: rtl/duc_lane.sv
// One antenna channel: stage 1 holds the selected, sign-extended term,
// stage 2 holds the channel's real output.
module duc_lane
  import duc_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          emit_i,
  input  logic [2:0]    sel_i,
  input  logic [DW-1:0] i_i,
  input  logic [DW-1:0] q_i,
  output logic [DW:0]   out_o
);

  logic signed [DW:0] i_ext;
  logic signed [DW:0] q_ext;
  logic signed [DW:0] term_d;
  logic signed [DW:0] term_q;
  logic signed [DW:0] out_q;

  // Widening before negation makes -(-2^(DW-1)) representable.
  assign i_ext = {i_i[DW-1], i_i};
  assign q_ext = {q_i[DW-1], q_i};

  // NOTE: every path of a combinational block must assign its outputs; the
  // default up front keeps synthesis from inferring a latch.
  always_comb begin
    term_d = '0;
    case (term_sel_e'(sel_i))
      SEL_POS_I: term_d = i_ext;
      SEL_NEG_I: term_d = -i_ext;
      SEL_POS_Q: term_d = q_ext;
      SEL_NEG_Q: term_d = -q_ext;
      default:   term_d = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // pre-edge values; reset is synchronous, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_q <= '0;
      out_q  <= '0;
    end else begin
      if (load_i) term_q <= term_d;
      if (emit_i) out_q  <= term_q;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/duc_mc.sv
// Multi-channel fs/4 up/down converter: one shared phase counter and valid
// pipeline driving NCH identical two-stage lanes.
module duc_mc
  import duc_pkg::*;
#(
  parameter int DW  = 6,
  parameter int NCH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NCH*DW-1:0]     i_in,
  input  logic [NCH*DW-1:0]     q_in,
  input  logic [1:0]            mode,
  input  logic                  sync,
  output logic                  out_valid,
  output logic [NCH*(DW+1)-1:0] out_duc,
  output logic [1:0]            phase_o
);

  logic [PHASE_W-1:0] ph_q;
  logic [PHASE_W-1:0] ph_d;
  logic [PHASE_W-1:0] ph_app;
  logic [PHASE_W-1:0] ph1_q;
  logic [PHASE_W-1:0] phase_q;
  logic               v1_q;
  logic               out_valid_q;
  term_sel_e          sel;

  // A sync request forces phase 0 for this sample; the counter then steps from 0.
  always_comb begin
    ph_app = sync ? '0 : ph_q;
    ph_d   = ph_q;
    if (in_valid) begin
      case (mode)
        MODE_UP: ph_d = ph_app + 2'd1;
        MODE_DN: ph_d = ph_app - 2'd1;
        default: ph_d = ph_app;
      endcase
    end
  end

  assign sel = term_select(mode, ph_app);

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q        <= '0;
      v1_q        <= 1'b0;
      ph1_q       <= '0;
      out_valid_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      ph_q        <= ph_d;
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (in_valid) ph1_q   <= ph_app;
      if (v1_q)     phase_q <= ph1_q;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    duc_lane #(.DW(DW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (in_valid),
      .emit_i (v1_q),
      .sel_i  (sel),
      .i_i    (i_in[k*DW +: DW]),
      .q_i    (q_in[k*DW +: DW]),
      .out_o  (out_duc[k*(DW+1) +: DW+1])
    );
  end

  assign out_valid = out_valid_q;
  assign phase_o   = phase_q;

endmodule

// File: tb/tb_duc_mc.sv
// Self-checking bench for duc_mc: directed vector table, hand-written corner
// sequences and random traffic, all compared against a behavioural model.
module tb_duc_mc;

  localparam int DW  = 6;
  localparam int NCH = 2;
  localparam int OW  = DW + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                sync;
  logic [1:0]          mode;
  logic [NCH*DW-1:0]   i_in;
  logic [NCH*DW-1:0]   q_in;
  logic                out_valid;
  logic [NCH*OW-1:0]   out_duc;
  logic [1:0]          phase_o;

  duc_mc #(.DW(DW), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .i_in      (i_in),
    .q_in      (q_in),
    .mode      (mode),
    .sync      (sync),
    .out_valid (out_valid),
    .out_duc   (out_duc),
    .phase_o   (phase_o)
  );

  always #5 clk = ~clk;

  typedef int ch_t [NCH];

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] md;
    logic       sy;
    int         i0;
    int         q0;
    int         ev;
    int         eph;
    int         eout;
  } vec_t;

  typedef struct {
    int ph;
    int out;
  } obs_t;

  int   n_total = 0;
  int   n_pass  = 0;
  vec_t tbl[$];
  obs_t obs_q[$];

  // Behavioural reference: the mixer is literally I*cos + Q*sin.
  int  cos_t [4] = '{0, -1, 0, 1};
  int  sin_t [4] = '{1, 0, -1, 0};
  int  m_ph;
  int  m_s1_v, m_s1_ph;
  ch_t m_s1_out;
  int  m_ov, m_oph;
  ch_t m_out;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int dut_out(input int k);
    logic signed [OW-1:0] t;
    t = out_duc[k*OW +: OW];
    return int'(t);
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [1:0] md,
                            input logic sy, input ch_t ii, input ch_t qq);
    int a;
    if (r) begin
      m_ph = 0; m_s1_v = 0; m_s1_ph = 0; m_ov = 0; m_oph = 0;
      for (int k = 0; k < NCH; k++) begin m_out[k] = 0; m_s1_out[k] = 0; end
    end else begin
      m_ov = m_s1_v;
      if (m_s1_v != 0) begin
        m_oph = m_s1_ph;
        m_out = m_s1_out;
      end
      m_s1_v = int'(v);
      if (v) begin
        a = sy ? 0 : m_ph;
        m_s1_ph = a;
        for (int k = 0; k < NCH; k++) begin
          if (md == 2'b11)      m_s1_out[k] = 0;
          else if (md == 2'b00) m_s1_out[k] = ii[k];
          else                  m_s1_out[k] = ii[k] * cos_t[a] + qq[k] * sin_t[a];
        end
        if (md == 2'b01)      m_ph = (a + 1) % 4;
        else if (md == 2'b10) m_ph = (a + 3) % 4;
        else                  m_ph = a;
      end
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at
  // the next falling edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] md,
                       input logic sy, input ch_t ii, input ch_t qq);
    rst = r; in_valid = v; mode = md; sync = sy;
    for (int k = 0; k < NCH; k++) begin
      i_in[k*DW +: DW] = ii[k][DW-1:0];
      q_in[k*DW +: DW] = qq[k][DW-1:0];
    end
    @(posedge clk);
    model_step(r, v, md, sy, ii, qq);
    @(negedge clk);
    check("out_valid", int'(out_valid), m_ov);
    check("phase_o", int'(phase_o), m_oph);
    for (int k = 0; k < NCH; k++)
      check($sformatf("out_duc_ch%0d", k), dut_out(k), m_out[k]);
    if (out_valid) obs_q.push_back('{int'(phase_o), dut_out(0)});
  endtask

  function automatic void add(input logic r, input logic v, input logic [1:0] md,
                              input logic sy, input int i0, input int q0,
                              input int ev, input int eph, input int eout);
    tbl.push_back('{r, v, md, sy, i0, q0, ev, eph, eout});
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(63)) - 32;
  endfunction

  ch_t iv, qv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sync = 1'b0; mode = 2'b00; i_in = '0; q_in = '0;
    @(negedge clk);

    // Up-conversion, I=5 Q=3: 3,-5,-3,5,3 with phases 0,1,2,3,0.
    add(1, 0, 2'b00, 0, 0, 0,    0, 0, 0);
    add(0, 1, 2'b01, 0, 5, 3,    0, 0, 0);
    add(0, 1, 2'b01, 0, 5, 3,    1, 0, 3);
    add(0, 1, 2'b01, 0, 5, 3,    1, 1, -5);
    add(0, 1, 2'b01, 0, 5, 3,    1, 2, -3);
    add(0, 1, 2'b01, 0, 5, 3,    1, 3, 5);
    add(0, 1, 2'b01, 0, 5, 3,    1, 0, 3);
    // Down-conversion: 3,5,-3,-5,3 with phases 0,3,2,1,0.
    add(1, 0, 2'b00, 0, 0, 0,    0, 0, 0);
    add(0, 1, 2'b10, 0, 5, 3,    0, 0, 0);
    add(0, 1, 2'b10, 0, 5, 3,    1, 0, 3);
    add(0, 1, 2'b10, 0, 5, 3,    1, 3, 5);
    add(0, 1, 2'b10, 0, 5, 3,    1, 2, -3);
    add(0, 1, 2'b10, 0, 5, 3,    1, 1, -5);
    add(0, 1, 2'b10, 0, 5, 3,    1, 0, 3);
    // Most negative input: negation must reach +32 without wrapping.
    add(1, 0, 2'b00, 0, 0, 0,    0, 0, 0);
    add(0, 1, 2'b01, 0, -32, -32, 0, 0, 0);
    add(0, 1, 2'b01, 0, -32, -32, 1, 0, -32);
    add(0, 1, 2'b01, 0, -32, -32, 1, 1, 32);
    add(0, 1, 2'b01, 0, -32, -32, 1, 2, 32);
    add(0, 1, 2'b01, 0, -32, -32, 1, 3, -32);
    // Gapped input 1,0,0,1,1; reset row also carries valid+sync to test priority.
    add(1, 1, 2'b01, 1, 5, 3,    0, 0, 0);
    add(0, 1, 2'b01, 0, 5, 3,    0, 0, 0);
    add(0, 0, 2'b01, 0, 5, 3,    1, 0, 3);
    add(0, 0, 2'b01, 0, 5, 3,    0, 0, 3);
    add(0, 1, 2'b01, 0, 5, 3,    0, 0, 3);
    add(0, 1, 2'b01, 0, 5, 3,    1, 1, -5);
    add(0, 0, 2'b01, 0, 5, 3,    1, 2, -3);
    add(0, 0, 2'b01, 0, 5, 3,    0, 2, -3);

    foreach (tbl[n]) begin
      iv[0] = tbl[n].i0; qv[0] = tbl[n].q0;
      iv[1] = rnd_sample(); qv[1] = rnd_sample();
      cycle(tbl[n].r, tbl[n].v, tbl[n].md, tbl[n].sy, iv, qv);
      check($sformatf("tbl%0d_valid", n), int'(out_valid), tbl[n].ev);
      check($sformatf("tbl%0d_phase", n), int'(phase_o), tbl[n].eph);
      check($sformatf("tbl%0d_out0", n), dut_out(0), tbl[n].eout);
    end

    // Sync realign, then bypass and mute holding the counter.
    iv = '{5, -1}; qv = '{3, 2};
    cycle(1, 0, 2'b00, 0, iv, qv);
    obs_q.delete();
    cycle(0, 1, 2'b01, 0, iv, qv);
    cycle(0, 1, 2'b01, 0, iv, qv);
    cycle(0, 1, 2'b01, 1, iv, qv);
    cycle(0, 1, 2'b01, 0, iv, qv);
    iv[0] = -7;
    cycle(0, 1, 2'b00, 0, iv, qv);
    iv[0] = 5;
    cycle(0, 1, 2'b11, 0, iv, qv);
    cycle(0, 1, 2'b01, 0, iv, qv);
    repeat (3) cycle(0, 0, 2'b00, 0, iv, qv);
    check("t5_count", obs_q.size(), 7);
    if (obs_q.size() == 7) begin
      int eo [7];
      int ep [7];
      eo = '{3, -5, 3, -5, -7, 0, -3};
      ep = '{0, 1, 0, 1, -1, -1, 2};
      for (int n = 0; n < 7; n++) begin
        check($sformatf("t5_out%0d", n), obs_q[n].out, eo[n]);
        if (ep[n] >= 0) check($sformatf("t5_ph%0d", n), obs_q[n].ph, ep[n]);
      end
    end

    // Reset with samples in flight: nothing emitted, next sample on phase 0.
    cycle(1, 0, 2'b00, 0, iv, qv);
    cycle(0, 1, 2'b01, 0, iv, qv);
    cycle(0, 1, 2'b01, 0, iv, qv);
    obs_q.delete();
    cycle(1, 1, 2'b01, 1, iv, qv);
    repeat (3) cycle(0, 0, 2'b01, 0, iv, qv);
    check("t6_flushed", obs_q.size(), 0);
    cycle(0, 1, 2'b01, 0, iv, qv);
    repeat (2) cycle(0, 0, 2'b01, 0, iv, qv);
    check("t6_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("t6_phase", obs_q[0].ph, 0);
      check("t6_out", obs_q[0].out, 3);
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic r, v, sy;
      logic [1:0] md;
      r  = ($urandom_range(99) < 2);
      v  = ($urandom_range(99) < 70);
      sy = ($urandom_range(99) < 10);
      md = 2'($urandom_range(3));
      for (int k = 0; k < NCH; k++) begin
        iv[k] = rnd_sample();
        qv[k] = rnd_sample();
      end
      cycle(r, v, md, sy, iv, qv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/duc_mc.md
DUC_MC -- requirements
Module: duc_mc

Interface
REQ-001 SHALL declare parameter DW, default 6, input I/Q sample width (two's complement, signed).
REQ-002 SHALL declare parameter NCH, default 2, number of independent antenna channels.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  fastest clock, all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  qualifies one I/Q sample per channel this cycle.
REQ-007 Port: i_in  input  NCH*DW  packed signed I samples; channel k occupies bits [k*DW +: DW].
REQ-008 Port: q_in  input  NCH*DW  packed signed Q samples; same packing as i_in.
REQ-009 Port: mode  input  2  00 bypass, 01 up +fs/4, 10 down -fs/4, 11 mute; sampled with in_valid.
REQ-010 Port: sync  input  1  phase realign request; sampled with in_valid.
REQ-011 Port: out_valid  output  1  qualifies out_duc.
REQ-012 Port: out_duc  output  NCH*(DW+1)  packed signed real output; channel k at [k*(DW+1) +: DW+1].
REQ-013 Port: phase_o  output  2  phase index applied to the sample currently on out_duc.

Function
REQ-014 A single 2-bit phase counter SHALL be shared by all channels and SHALL advance only on cycles with in_valid=1.
REQ-015 Phase table SHALL be (cos,sin): p0=(0,+1), p1=(-1,0), p2=(0,-1), p3=(+1,0).
REQ-016 Per channel, result SHALL be I*cos + Q*sin for the applied phase; exactly one term is non-zero, so there is no adder overflow.
REQ-017 Negation SHALL be computed at DW+1 bits; -(-2^(DW-1)) = +2^(DW-1) SHALL be exact, with no saturation or wrap.
REQ-018 Mode 01: applied phase is the counter value; afterwards the counter increments modulo 4 (3 -> 0).
REQ-019 Mode 10: applied phase is the counter value; afterwards the counter decrements modulo 4 (0 -> 3).
REQ-020 Mode 00: output SHALL be i_in sign-extended to DW+1; the phase counter SHALL hold.
REQ-021 Mode 11: output SHALL be 0 with out_valid still asserted; the phase counter SHALL hold.
REQ-022 sync=1 with in_valid=1: that sample SHALL use phase 0, and the counter SHALL then step from 0 per mode.
REQ-023 sync with in_valid=0 SHALL be ignored.
REQ-024 Latency SHALL be exactly 2 clk cycles from the in_valid edge to the out_valid edge.
REQ-025 Pipeline: stage 1 registers the per-channel selected, sign-extended term and the phase; stage 2 registers out_duc, out_valid and phase_o.
REQ-026 out_valid SHALL follow the in_valid stream delayed by 2 with no gaps or duplicates; back-to-back samples SHALL sustain 1 sample per clk.
REQ-027 When out_valid=0, out_duc and phase_o SHALL hold their last values.
REQ-028 A mode change between samples SHALL take effect on the first sample that carries it, with no flush.

Reset
REQ-029 On rst=1: phase counter=0, all pipeline valids=0, out_duc=0, phase_o=0, out_valid=0 at the next clk edge.
REQ-030 rst SHALL have priority over in_valid and sync on the same cycle; in-flight samples SHALL be discarded and never emitted.
REQ-031 The first valid sample after reset release SHALL use phase 0.

Structure
REQ-032 Package duc_pkg SHALL hold the mode encoding constants (MODE_BYP, MODE_UP, MODE_DN, MODE_MUTE), the phase-table constants and the phase width.
REQ-033 Sub-module duc_lane SHALL implement one channel's two-stage datapath; duc_mc SHALL instantiate it NCH times and own the shared phase counter and valid pipeline.

Verification
REQ-034 Test 1: DW=6, NCH=2, mode=01, continuous valid, ch0 I=5, Q=3 -> ch0 outputs 3,-5,-3,5,3... starting 2 cycles after the first valid; phase_o 0,1,2,3,0.
REQ-035 Test 2: mode=10, same input -> ch0 outputs 3,5,-3,-5,3...; phase_o 0,3,2,1,0.
REQ-036 Test 3: mode=01, I=-32, Q=-32 -> outputs -32,+32,+32,-32 at 7 bits with no wrap.
REQ-037 Test 4: in_valid pattern 1,0,0,1,1, mode=01 -> out_valid 2 cycles later with the same gaps; phases 0,1,2; out_duc holds during gaps.
REQ-038 Test 5: after 2 samples (counter=2), sync=1 with valid -> that sample uses p0, the next uses p1; mode 00 I=-7 -> out -7; mode 11 -> 0 with the counter held.
REQ-039 Test 6: rst pulsed while 2 samples are in flight -> no out_valid afterwards for those samples; the next sample uses p0.
